// File: rtl/fifo_splitter_n_pkg.sv
// fifo_splitter_n_pkg
//   Shared sizing helpers for the broadcast splitter and its callers.
//   clog2    : ceil(log2(value)), used by instantiating code to derive
//              ADDR_WIDTH from a desired buffer depth.
//   depth_of : entries in a buffer addressed by addr_width bits.
package fifo_splitter_n_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/fifo_splitter_n_fifo_channel.sv
// fifo_channel
//   One DEPTH-entry first-word-fall-through buffer. The head word is read
//   straight from storage, so a pushed word becomes visible the cycle after
//   the push edge (no same-cycle bypass).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write wdata this edge (caller guarantees not full)
//   pop_ready  : consumer ready; ignored while empty
//   wdata      : word to write
//   rdata      : head word, meaningful when valid
//   valid      : buffer non-empty
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module fifo_channel
    import fifo_splitter_n_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop_ready,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int                  DEPTH     = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);
    assign valid = ~empty;
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Guard against a push into a full buffer even though the top never
    // issues one; a full buffer never passes a word through on a pop.
    assign do_push = push & ~full;
    assign do_pop  = pop_ready & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are only observed when valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fifo_splitter_n.sv
// fifo_splitter_n
//   Broadcasts one valid/ready token stream to OUT_NUM independent FWFT
//   buffers. A per-token mask selects which outputs receive it; a token
//   enters every selected buffer on the same edge or none of them.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   data_in         : input token
//   data_in_mask    : bit i = deliver to output i
//   data_in_valid   : input token valid
//   data_in_ready   : token accepted when valid & ready
//   data_out        : channel i head at [i*WIDTH +: WIDTH]
//   data_out_valid  : per-channel head valid
//   data_out_ready  : per-channel consumer ready
//   count           : channel i occupancy at [i*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]
//   idle            : every channel empty
module fifo_splitter_n
    import fifo_splitter_n_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int OUT_NUM    = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WIDTH-1:0]                  data_in,
    input  logic [OUT_NUM-1:0]                data_in_mask,
    input  logic                              data_in_valid,
    output logic                              data_in_ready,
    output logic [OUT_NUM*WIDTH-1:0]          data_out,
    output logic [OUT_NUM-1:0]                data_out_valid,
    input  logic [OUT_NUM-1:0]                data_out_ready,
    output logic [OUT_NUM*(ADDR_WIDTH+1)-1:0] count,
    output logic                              idle
);

    logic [OUT_NUM-1:0][WIDTH-1:0]      ch_data;
    logic [OUT_NUM-1:0][ADDR_WIDTH:0]   ch_count;
    logic [OUT_NUM-1:0]                 ch_full;
    logic [OUT_NUM-1:0]                 ch_empty;
    logic [OUT_NUM-1:0]                 ch_push;
    logic                               push_en;

    // Ready depends only on the mask and registered fullness, never on
    // data_out_ready: a full channel with a same-cycle pop still blocks.
    always_comb begin
        data_in_ready = 1'b1;
        for (int i = 0; i < OUT_NUM; i++) begin
            if (data_in_mask[i] && ch_full[i]) data_in_ready = 1'b0;
        end
    end

    assign push_en = data_in_valid & data_in_ready;
    assign ch_push = {OUT_NUM{push_en}} & data_in_mask;

    for (genvar g = 0; g < OUT_NUM; g++) begin : g_ch
        fifo_channel #(
            .WIDTH      (WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .push      (ch_push[g]),
            .pop_ready (data_out_ready[g]),
            .wdata     (data_in),
            .rdata     (ch_data[g]),
            .valid     (data_out_valid[g]),
            .count     (ch_count[g]),
            .full      (ch_full[g]),
            .empty     (ch_empty[g])
        );
    end

    assign data_out = ch_data;
    assign count    = ch_count;
    assign idle     = &ch_empty;

endmodule
